// File: rtl/arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : arb_pkg
//  Purpose  : Shared types, defaults and width helper for the rr_arbiter slice.
//  Revision : 1.0 - initial release
// ============================================================================
package arb_pkg;

    localparam int DEF_N        = 8;
    localparam int DEF_MAX_HOLD = 16;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    localparam logic [0:0] c_ST_IDLE  = IDLE;
    localparam logic [0:0] c_ST_GRANT = GRANT;

    function automatic int arb_id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/arb_pick.sv
`default_nettype none
// ============================================================================
//  Module   : arb_pick
//  Purpose  : Rotating priority pick: first set req bit at or above ptr, wrapping.
//  Revision : 1.0 - initial release
// ============================================================================
module arb_pick
    import arb_pkg::*;
#(
    parameter int N    = DEF_N,
    parameter int ID_W = arb_id_w(DEF_N)
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic [ID_W-1:0] win,
    output logic            any
);

    localparam logic [ID_W:0] c_N_EXT = ID_W'(N);

    logic [N-1:0]    w_rot;
    logic [ID_W-1:0] w_idx;
    logic [ID_W:0]   w_sum;

    // Rotating right by ptr places requester ptr at bit 0.
    assign w_rot = N'({req, req} >> ptr);
    assign any   = |req;

    always_comb begin
        w_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_idx = ID_W'(i);
            end
        end
    end

    always_comb begin
        w_sum = {1'b0, ptr} + {1'b0, w_idx};
        if (w_sum >= c_N_EXT) begin
            w_sum = w_sum - c_N_EXT;
        end
    end

    assign win = w_sum[ID_W-1:0];

endmodule
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arbiter
//  Purpose  : Round-robin arbiter with registered one-hot grant; optional hold
//             timeout enabled by defining ARB_TIMEOUT_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import arb_pkg::*;
#(
    parameter int N        = DEF_N,
    parameter int MAX_HOLD = DEF_MAX_HOLD,
    localparam int ID_W    = arb_id_w(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    input  logic            done,
    output logic [N-1:0]    gnt,
    output logic [ID_W-1:0] gnt_id,
    output logic            gnt_valid,
    output logic            timeout
);

    localparam logic [ID_W-1:0] c_LAST    = ID_W'(N - 1);
    localparam logic [ID_W-1:0] c_ONE     = ID_W'(1);
    localparam logic [N-1:0]    c_GNT_ONE = N'(1);

    logic [0:0]      r_state;
    logic [ID_W-1:0] r_ptr;
    logic [N-1:0]    r_gnt;
    logic [ID_W-1:0] r_gnt_id;
    logic            r_gnt_valid;
    logic            r_timeout;

    logic [ID_W-1:0] w_win;
    logic            w_any;
    logic            w_release;
    logic            w_expire;
    logic [ID_W-1:0] w_ptr_next;

    arb_pick #(
        .N    (N),
        .ID_W (ID_W)
    ) u_pick (
        .req (req),
        .ptr (r_ptr),
        .win (w_win),
        .any (w_any)
    );

    assign w_release  = done | ~req[r_gnt_id];
    assign w_ptr_next = (r_gnt_id == c_LAST) ? '0 : r_gnt_id + c_ONE;

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] c_HOLD_LAST = 8'(MAX_HOLD - 1);

    logic [7:0] r_hold;

    assign w_expire = (r_state == c_ST_GRANT) && (r_hold == c_HOLD_LAST);

    // Held at zero outside GRANT, so every new grant starts counting from 0.
    always_ff @(posedge clk) begin
        if (rst || (r_state == c_ST_IDLE) || w_release || w_expire) begin
            r_hold <= '0;
        end else begin
            r_hold <= r_hold + 8'd1;
        end
    end
`else
    logic w_unused_cfg;
    assign w_unused_cfg = (MAX_HOLD > 0);
    assign w_expire     = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_ST_IDLE;
            r_ptr       <= '0;
            r_gnt       <= '0;
            r_gnt_id    <= '0;
            r_gnt_valid <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            if (r_state == c_ST_IDLE) begin
                if (w_any) begin
                    r_state     <= c_ST_GRANT;
                    r_gnt       <= c_GNT_ONE << w_win;
                    r_gnt_id    <= w_win;
                    r_gnt_valid <= 1'b1;
                end
            end else if (w_release || w_expire) begin
                // A normal release on the expiry edge suppresses the timeout pulse.
                r_state     <= c_ST_IDLE;
                r_gnt       <= '0;
                r_gnt_valid <= 1'b0;
                r_ptr       <= w_ptr_next;
                r_timeout   <= ~w_release;
            end
        end
    end

    assign gnt       = r_gnt;
    assign gnt_id    = r_gnt_id;
    assign gnt_valid = r_gnt_valid;
    assign timeout   = r_timeout;

endmodule
`default_nettype wire

// File: doc/rr_arbiter.md
# rr_arbiter

Round-robin arbiter that shares a single downstream resource among up to eight requesters. Each cycle in which the resource is free, it selects one requester by rotating priority. That requester holds the grant until it signals completion or drops its request. Internally the block is a two-state FSM wrapped around a rotated priority-encode pick, and it sits between requester agents and the shared datapath.

## Interface
- N, 8: number of requesters, legal range 2..8.
- MAX_HOLD, 16: maximum grant length in cycles. Used only when ARB_TIMEOUT_EN is defined. Legal range 2..255.
- clk  in  1  single clock, rising-edge.
- rst  in  1  reset, synchronous and active-high.
- req  in  N  request vector, one bit per requester; level-sensitive.
- done  in  1  owner finished; honoured only while gnt_valid=1.
- gnt  out  N  one-hot grant, registered.
- gnt_id  out  ID_W  index of the owner; ID_W = clog2(N). Meaningful only while gnt_valid=1.
- gnt_valid  out  1  a grant is active.
- timeout  out  1  one-cycle pulse when a grant is forcibly revoked.

## Operation
- **States:** IDLE, GRANT.
- **Reset values:** state=IDLE, gnt=0, gnt_id=0, gnt_valid=0, timeout=0, ptr=0.
- **Pick (combinational):** search req starting at index ptr, upward with wrap-around to 0. The first set bit wins. ptr is a clog2(N)-bit register.
- **IDLE:**
  - If req≠0 at a rising edge, go to GRANT.
  - On that same edge, load gnt=onehot(win), gnt_id=win, gnt_valid=1.
  - If req=0, stay in IDLE.
- **GRANT:** release when done=1 or req[gnt_id]=0 at a rising edge. On the release edge:
  - gnt=0, gnt_valid=0, gnt_id holds its value.
  - ptr = (gnt_id+1) mod N.
  - Go to IDLE.
- **Request changes mid-grant:** requests other than the owner's never pre-empt the owner. A new request arriving mid-grant waits.
- **Done outside a grant:** done while in IDLE is ignored.
- **Simultaneous done and owner-req drop:** a single release.
- **Wrap-around:** ptr=N-1 with a release advances ptr to 0.
- **Reset mid-grant:** outputs reach reset values on that edge, and ptr returns to 0.

## Timing
- Grant latency is 1 edge. If req is set before edge k while in IDLE, gnt_valid is high after edge k.
- Release latency is 1 edge. If done is sampled at edge k, gnt_valid is low after edge k.
- Mandatory idle gap: gnt_valid is low for at least 1 cycle between consecutive grants. The next grant appears after edge k+1 at the earliest.
- Throughput with continuous requests is 1 grant per (hold length + 1) cycles.
- All outputs are registered; there is no combinational path from req or done to outputs.

## Configuration
- **ARB_TIMEOUT_EN defined:**
  - An 8-bit hold counter clears on grant and increments each cycle in GRANT.
  - When the counter = MAX_HOLD-1 and no normal release occurs on that edge, the grant is forcibly released: normal release actions, plus timeout=1 for exactly one cycle.
  - A normal release on the same edge takes precedence, and timeout stays 0.
  - The counter resets to 0.
- **ARB_TIMEOUT_EN undefined:** no counter is built, timeout is tied to 0, and grants last indefinitely.

## Structure
- **Shared package arb_pkg:**
  - state enum {IDLE, GRANT}
  - default N=8
  - ID_W derivation, clog2(N)
  - default MAX_HOLD
- **One sub-module arb_pick:** purely combinational. It takes req and ptr and outputs win index plus any flag. It rotates req by ptr, priority-encodes the lowest set bit, and adds ptr back mod N.
- **rr_arbiter itself:** holds the FSM, ptr, and output registers, plus the optional counter.

## Test plan
- **Reset mid-grant:** grant owner 5, assert rst for 1 cycle → gnt=0, gnt_valid=0, timeout=0; next grant with req=8'hFF goes to 0 (ptr=0).
- **Round-robin:** req=8'hFF held, done pulsed each grant → gnt_id sequence 0,1,2,…,7,0, with exactly one idle cycle between grants.
- **Sparse/wrap:** req=8'b1000_0010 starting at ptr=0 → grant 1; after release, grant 7; after release, grant 1 (wrap).
- **No pre-emption:** owner 2 holding; raise req[0] → gnt stays 8'h04 until done; next grant is 0 only if no requester in 3..7.
- **Owner drops req:** owner 4 deasserts req[4] at edge k → gnt_valid low after k; ptr=5.
- **Timeout (ARB_TIMEOUT_EN, MAX_HOLD=4):** owner 3 holds without done → gnt_valid high for exactly 4 cycles, timeout pulses 1 cycle on release, ptr=4.
  - Variant: done on the 4th cycle → timeout stays 0.
